// File: rtl/alu_issue_sequencer.sv
// Issue/writeback sequencer around a registered ALU: reads operands from a local
// register file, pulses the ALU enable once, then writes the result back and updates S/Z/C.
module alu_issue_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        issue_opcode,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic              issue_use_imm,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              alu_enable,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cflag,
  output logic [2:0]        flags_q,
  output logic              done,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_ADC = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_INC = 5'h03;
  localparam logic [4:0] OP_DEC = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_CMP = 5'h09;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [2:0]          flags_d;
  logic [4:0]          alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_in_a_q, alu_in_a_d;
  logic [DATA_W-1:0]   alu_in_b_q, alu_in_b_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                op_legal;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // S and Z come from the written-back result; C is whatever the ALU holds.
  function automatic logic [2:0] wb_flags(input logic [DATA_W-1:0] res, input logic c);
    return {res[DATA_W-1], (res == '0), c};
  endfunction

  assign op_legal   = is_legal(alu_opcode_q);
  assign alu_opcode = alu_opcode_q;
  assign alu_in_a   = alu_in_a_q;
  assign alu_in_b   = alu_in_b_q;
  assign dbg_data   = regs_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_valid && issue_ready) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A reset arriving mid-instruction suppresses the enable and the retire pulses.
  always_comb begin
    issue_ready = 1'b0;
    alu_enable  = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: issue_ready = !ld_en;
      S_EXEC: alu_enable  = op_legal && !rst;
      S_WB: begin
        done    = !rst;
        illegal = !rst && !op_legal;
      end
      default: ;
    endcase
  end

  always_comb begin
    regs_d       = regs_q;
    flags_d      = flags_q;
    alu_opcode_d = alu_opcode_q;
    alu_in_a_d   = alu_in_a_q;
    alu_in_b_d   = alu_in_b_q;
    rd_d         = rd_q;
    case (state_q)
      S_IDLE: begin
        if (ld_en) begin
          regs_d[ld_addr] = ld_data;
        end else if (issue_valid) begin
          alu_opcode_d = issue_opcode;
          rd_d         = issue_rd;
          alu_in_a_d   = regs_q[issue_rd];
          alu_in_b_d   = issue_use_imm ? issue_imm : regs_q[issue_rs];
        end
      end
      S_WB: begin
        if (op_legal) begin
          flags_d = wb_flags(alu_out, alu_cflag);
          if (alu_opcode_q != OP_CMP) regs_d[rd_q] = alu_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q      <= '0;
      alu_opcode_q <= '0;
      alu_in_a_q   <= '0;
      alu_in_b_q   <= '0;
      rd_q         <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      flags_q      <= flags_d;
      alu_opcode_q <= alu_opcode_d;
      alu_in_a_q   <= alu_in_a_d;
      alu_in_b_q   <= alu_in_b_d;
      rd_q         <= rd_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small registered ALU attached.
module tb_alu_issue_sequencer;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_ADC = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_INC = 5'h03;
  localparam logic [4:0] OP_DEC = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_CMP = 5'h09;
  localparam logic [4:0] OP_BAD = 5'h1F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_opcode = '0;
  logic [2:0]  issue_rd = '0;
  logic [2:0]  issue_rs = '0;
  logic        issue_use_imm = 1'b0;
  logic [15:0] issue_imm = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        alu_enable;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_in_a, alu_in_b;
  logic [15:0] alu_out = '0;
  logic        alu_cflag = 1'b0;
  logic [2:0]  flags_q;
  logic        done, illegal;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_rd(issue_rd), .issue_rs(issue_rs),
    .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_cflag(alu_cflag),
    .flags_q(flags_q), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Registered ALU: result and carry update only on enable; carry borrows on subtract.
  logic [16:0] alu_t;
  logic        alu_c_nxt;
  always_comb begin
    alu_t     = '0;
    alu_c_nxt = alu_cflag;
    case (alu_opcode)
      OP_ADD:         begin alu_t = {1'b0, alu_in_a} + {1'b0, alu_in_b}; alu_c_nxt = alu_t[16]; end
      OP_ADC:         begin alu_t = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_cflag}; alu_c_nxt = alu_t[16]; end
      OP_SUB, OP_CMP: begin alu_t = {1'b0, alu_in_a} - {1'b0, alu_in_b}; alu_c_nxt = alu_t[16]; end
      OP_INC:         begin alu_t = {1'b0, alu_in_a} + 17'd1; alu_c_nxt = alu_t[16]; end
      OP_DEC:         begin alu_t = {1'b0, alu_in_a} - 17'd1; alu_c_nxt = alu_t[16]; end
      OP_AND:         alu_t = {1'b0, alu_in_a & alu_in_b};
      OP_OR:          alu_t = {1'b0, alu_in_a | alu_in_b};
      OP_XOR:         alu_t = {1'b0, alu_in_a ^ alu_in_b};
      OP_NOT:         alu_t = {1'b0, ~alu_in_a};
      default:        ;
    endcase
  end
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out   <= alu_t[15:0];
      alu_cflag <= alu_c_nxt;
    end
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic        use_imm;
    logic [15:0] imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_val;
    logic [2:0]  exp_flags;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_issue(input vec_t v);
    @(negedge clk);
    issue_opcode = v.op; issue_rd = v.rd; issue_rs = v.rs;
    issue_use_imm = v.use_imm; issue_imm = v.imm; issue_valid = 1'b1;
    #1 chk("ready_before_issue", 32'(issue_ready), 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_opcode = 5'($urandom); issue_rd = 3'($urandom); issue_rs = 3'($urandom);
    issue_use_imm = 1'($urandom); issue_imm = 16'($urandom);
    @(negedge clk);
    chk("exec_ready", 32'(issue_ready), 32'd0);
    chk("exec_done", 32'(done), 32'd0);
    chk("exec_alu_enable", 32'(alu_enable), 32'(!v.exp_ill));
    @(negedge clk);
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_illegal", 32'(illegal), 32'(v.exp_ill));
    chk("wb_ready", 32'(issue_ready), 32'd0);
    chk("wb_alu_enable", 32'(alu_enable), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(issue_ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    dbg_addr = v.rd;
    #1 chk("result_reg", 32'(dbg_data), 32'(v.exp_val));
    chk("result_flags", 32'(flags_q), 32'(v.exp_flags));
  endtask

  initial begin
    //          op      rd    rs    imm?  imm       a         b         exp_val   flags   ill
    tbl[0]  = '{OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0005, 16'h0003, 16'h0008, 3'b000, 1'b0};
    tbl[1]  = '{OP_ADD, 3'd1, 3'd2, 1'b1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 3'b011, 1'b0};
    tbl[2]  = '{OP_ADC, 3'd1, 3'd2, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 3'b000, 1'b0};
    tbl[3]  = '{OP_CMP, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0003, 16'h0003, 16'h0003, 3'b010, 1'b0};
    tbl[4]  = '{OP_SUB, 3'd3, 3'd5, 1'b0, 16'h0000, 16'h0002, 16'h0005, 16'hFFFD, 3'b101, 1'b0};
    tbl[5]  = '{OP_AND, 3'd3, 3'd5, 1'b0, 16'h0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 1'b0};
    tbl[6]  = '{OP_OR,  3'd3, 3'd5, 1'b1, 16'h0001, 16'h8000, 16'h0000, 16'h8001, 3'b101, 1'b0};
    tbl[7]  = '{OP_XOR, 3'd6, 3'd6, 1'b0, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 3'b011, 1'b0};
    tbl[8]  = '{OP_INC, 3'd7, 3'd0, 1'b1, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 3'b011, 1'b0};
    tbl[9]  = '{OP_DEC, 3'd0, 3'd5, 1'b1, 16'h5555, 16'h0000, 16'h0000, 16'hFFFF, 3'b101, 1'b0};
    tbl[10] = '{OP_NOT, 3'd2, 3'd5, 1'b1, 16'h0F0F, 16'h00FF, 16'h0000, 16'hFF00, 3'b101, 1'b0};
    tbl[11] = '{OP_ADC, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 3'b100, 1'b0};
    tbl[12] = '{OP_BAD, 3'd1, 3'd2, 1'b1, 16'h0001, 16'h1234, 16'h0000, 16'h1234, 3'b100, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dbg_addr = 3'd1;
    #1;
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_alu_enable", 32'(alu_enable), 32'd0);
    chk("reset_flags", 32'(flags_q), 32'd0);
    chk("reset_alu_in_a", 32'(alu_in_a), 32'd0);
    chk("reset_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("reset_r1", 32'(dbg_data), 32'd0);

    for (int i = 0; i < 13; i++) begin
      load(tbl[i].rd, tbl[i].a);
      if (!tbl[i].use_imm && tbl[i].rs != tbl[i].rd) load(tbl[i].rs, tbl[i].b);
      run_issue(tbl[i]);
    end

    // Load and issue presented together: load wins, issue is taken a cycle later.
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0010;
    issue_opcode = OP_ADD; issue_rd = 3'd1; issue_rs = 3'd0;
    issue_use_imm = 1'b1; issue_imm = 16'h0001; issue_valid = 1'b1;
    #1 chk("ld_collide_ready", 32'(issue_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0; dbg_addr = 3'd1;
    #1 chk("ld_collide_ready_next", 32'(issue_ready), 32'd1);
    chk("ld_collide_loaded", 32'(dbg_data), 32'h0010);
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
    chk("ld_collide_exec_ready", 32'(issue_ready), 32'd0);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hBEEF;
    @(negedge clk);
    chk("ld_collide_done", 32'(done), 32'd1);
    @(negedge clk);
    ld_en = 1'b0;
    #1 chk("ld_collide_idle_ready", 32'(issue_ready), 32'd1);
    dbg_addr = 3'd1;
    #1 chk("ld_collide_r1", 32'(dbg_data), 32'h0011);
    dbg_addr = 3'd3;
    #1 chk("ld_busy_ignored_r3", 32'(dbg_data), 32'h8001);
    chk("ld_collide_flags", 32'(flags_q), 32'd0);

    // Reset during EXEC aborts the DEC: no done, register file cleared.
    load(3'd4, 16'h8000);
    @(negedge clk);
    issue_opcode = OP_DEC; issue_rd = 3'd4; issue_rs = 3'd0;
    issue_use_imm = 1'b0; issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0; dbg_addr = 3'd4;
    #1 chk("abort_ready", 32'(issue_ready), 32'd1);
    chk("abort_r4", 32'(dbg_data), 32'd0);
    chk("abort_flags", 32'(flags_q), 32'd0);
    @(negedge clk);
    chk("abort_done_after", 32'(done), 32'd0);
    chk("abort_r4_after", 32'(dbg_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
